// File: rtl/toy_cpu_sequencer.sv
// Instruction sequencer for the toy CPU: packs a byte stream into 3-byte words,
// buffers them in a small FIFO and issues them under run/step control with HALT support.
module toy_cpu_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic                     run,
  input  logic                     step,
  input  logic                     cpu_busy,
  output logic                     op_valid,
  output logic [2:0]               opcode,
  output logic [2:0]               src_a,
  output logic [2:0]               src_b,
  output logic [2:0]               dest,
  output logic [7:0]               imm,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [2:0] dest;
    logic [7:0] imm;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HALTED
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    phase_q;
  logic [2:0]    stg_opcode_q, stg_src_a_q, stg_src_b_q, stg_dest_q;
  instr_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  instr_t        fields_q;
  instr_t        head;
  instr_t        push_word;
  logic          step_prev_q, step_pending_q;
  logic          byte_acc, push, pop, load, clr_pend;
  logic          issue_en, step_rise, head_halt, has_word;

  // ---------------------------------------------------------------------------
  // Byte assembly
  // ---------------------------------------------------------------------------
  assign in_ready = (count_q < FULL);
  assign byte_acc = in_valid && in_ready;
  assign push     = byte_acc && (phase_q == 2'd2);

  assign push_word = '{opcode: stg_opcode_q, src_a: stg_src_a_q,
                       src_b:  stg_src_b_q,  dest:  stg_dest_q,
                       imm:    in_data};

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q      <= 2'd0;
      stg_opcode_q <= 3'd0;
      stg_src_a_q  <= 3'd0;
      stg_src_b_q  <= 3'd0;
      stg_dest_q   <= 3'd0;
    end else if (byte_acc) begin
      case (phase_q)
        2'd0: begin
          stg_opcode_q <= in_data[5:3];
          stg_src_a_q  <= in_data[2:0];
          phase_q      <= 2'd1;
        end
        2'd1: begin
          stg_src_b_q <= in_data[5:3];
          stg_dest_q  <= in_data[2:0];
          phase_q     <= 2'd2;
        end
        default: phase_q <= 2'd0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction FIFO
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately not reset; pointers and count
  // define which entries are meaningful, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head      = mem[rd_ptr_q];
  assign has_word  = (count_q != '0);
  assign head_halt = (head.opcode == 3'b111) && (head.imm == 8'hFF);

  // ---------------------------------------------------------------------------
  // Step edge capture; a new edge wins over a same-cycle consume
  // ---------------------------------------------------------------------------
  assign step_rise = step && !step_prev_q;
  assign issue_en  = run || step_pending_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_prev_q    <= 1'b0;
      step_pending_q <= 1'b0;
    end else begin
      step_prev_q <= step;
      if (step_rise)     step_pending_q <= 1'b1;
      else if (clr_pend) step_pending_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: all outputs of this block get a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load     = 1'b0;
    clr_pend = 1'b0;
    case (state_q)
      IDLE: begin
        if (has_word && issue_en) begin
          pop      = 1'b1;
          clr_pend = 1'b1;
          if (head_halt) begin
            state_d = HALTED;
          end else begin
            load    = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!cpu_busy) begin
          if (has_word && run && !head_halt) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HALTED: begin
        // run is ignored here; only a step request releases the halt
        if (step_pending_q) begin
          clr_pend = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      fields_q <= '0;
    else if (load) fields_q <= head;
  end

  assign op_valid   = (state_q == ISSUE);
  assign halted     = (state_q == HALTED);
  assign opcode     = fields_q.opcode;
  assign src_a      = fields_q.src_a;
  assign src_b      = fields_q.src_b;
  assign dest       = fields_q.dest;
  assign imm        = fields_q.imm;
  assign fifo_count = count_q;

  // ---------------------------------------------------------------------------
  // Protocol invariants
  // ---------------------------------------------------------------------------
  a_no_push_full : assert property (@(posedge clk) disable iff (!rst)
    !(push && (count_q == FULL)));

  a_no_pop_empty : assert property (@(posedge clk) disable iff (!rst)
    !(pop && !has_word));

  a_stall_stable : assert property (@(posedge clk) disable iff (!rst)
    (op_valid && cpu_busy) |=> (op_valid && $stable(fields_q)));

endmodule

// File: doc/toy_cpu_sequencer.md
# toy_cpu_sequencer

Instruction sequencer that feeds the toy CPU datapath. It assembles 3-byte instruction words from an 8-bit byte stream and buffers them in a small FIFO. It issues them one at a time on the CPU's op_valid/opcode/src_a/src_b/dest/imm interface, under run/step control with a valid/busy handshake. It sits between the chip's byte-wide input pins and the CPU core, and also interprets a HALT pseudo-instruction.

## Interface
- DEPTH, 4: instruction FIFO depth in words; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte stream valid.
- in_data  in  8  byte stream data.
- in_ready  out  1  byte accepted when in_valid && in_ready; combinational, = (fifo_count < DEPTH).
- run  in  1  level: issue continuously while high.
- step  in  1  rising edge requests one issue (or HALT release).
- cpu_busy  in  1  CPU stall; instruction accepted when op_valid && !cpu_busy.
- op_valid  out  1  instruction valid to CPU.
- opcode  out  3  / src_a out 3 / src_b out 3 / dest out 3 / imm out 8  instruction fields, registered.
- fifo_count  out  $clog2(DEPTH)+1  buffered words.
- halted  out  1  high while FSM is in HALTED.

## Operation
- Byte assembly: 2-bit phase counter 0→1→2→0, advanced per accepted byte.
  - byte0: opcode=[5:3], src_a=[2:0]; [7:6] ignored.
  - byte1: src_b=[5:3], dest=[2:0]; [7:6] ignored.
  - byte2: imm=[7:0]; the completed 20-bit word is pushed into the FIFO on the same edge.
  - Partial fields are held in staging registers; bytes 0/1 are also gated by in_ready.
- FIFO: circular, DEPTH entries, wrap-around pointers; push and pop on the same edge leave the count unchanged. Pop never occurs when empty; push never occurs when full.
- step_pending: set on a step rising edge (registered previous step), cleared when it is consumed by an issue or a HALT release. Multiple edges before consumption collapse into one.
- issue_en = run || step_pending.
- FSM states:
  - IDLE: op_valid=0. If count>0 and issue_en: pop.
    - Popped word is HALT (opcode=3'b111 and imm=8'hFF): discard it, clear step_pending, go to HALTED.
    - Otherwise: load the fields, clear step_pending, go to ISSUE.
  - ISSUE: op_valid=1 and fields held stable while cpu_busy=1. On accept:
    - if count>0 and run=1 and the next word is not HALT: pop and load it, stay in ISSUE (back-to-back).
    - otherwise go to IDLE and drop op_valid.
  - HALTED: op_valid=0; run is ignored. A step rising edge clears step_pending and goes to IDLE; no instruction is issued on that edge.
- Outputs hold their last field values after op_valid drops.
- Reset (async, any time): FSM=IDLE, phase=0, pointers/count=0, step_pending=0, op_valid=0, all fields=0, halted=0. A partially assembled word is discarded. in_ready=1 after reset.

## Timing
- A word becomes visible in fifo_count on the edge after byte2 is accepted. Earliest op_valid rises on the following edge: 1 idle cycle between the byte2 accept and op_valid.
- Back-to-back issue in run mode: 1 instruction per cycle while cpu_busy=0.
- A step edge sampled at edge E sets step_pending after E. The issue occurs at E+1 if the FIFO is non-empty.
- cpu_busy affects only ISSUE; it never blocks loading.
- When full with a simultaneous pop, in_ready is still 0 that cycle (based on the registered count).

## Test plan
- Reset: drive rst=0 mid-run → op_valid=0, fifo_count=0, halted=0, in_ready=1, all fields 0.
- Single load, run=1: bytes 0x2B,0x15,0xA5 → op_valid high one cycle with opcode=5, src_a=3, src_b=2, dest=5, imm=0xA5; fifo_count returns to 0.
- Fill, run=0: 4 words (12 bytes) → fifo_count=4, in_ready=0, 13th byte not accepted. One step pulse → exactly one issue, count=3. Two step edges within 1 cycle while ISSUE is held → only one further issue.
- Stall: run=1, 2 words queued, cpu_busy=1 for 3 cycles after op_valid rises → fields and op_valid stable, count unchanged. Release → first word accepted and second word issued on the next cycle, back-to-back.
- HALT: queue 0x38,0x00,0xFF, then 0x08,0x00,0x01 with run=1 → halted=1, no op_valid, count=1. Step pulse → halted=0. Next cycle (run=1) opcode=1, imm=0x01 issued.
- Reset mid-load: rst low after byte0 0x3F, release → load 0x2B,0x15,0xA5 → decodes as in the single-load test (the stale byte is discarded).
